// File: rtl/alu_j.sv
// ---------------------------------------------------------------------------
// alu_j : single-cycle registered ALU
//
// Samples opcode/operands/param on every rising clk edge and registers the
// result together with a status flag vector. A new operation can be issued
// every cycle; there is no handshake.
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   synchronous active-low reset (clears result and status)
//   opcode    in   operation select (0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR,
//                  5 NOT, 6 XOR, 7 SHL, 8 SHR, 9 VAL, 10 CMP, others NOP)
//   operand1  in   first operand
//   operand2  in   second operand
//   param     in   shift amount (SHL/SHR) or immediate value (VAL)
//   result    out  registered result
//   status    out  registered flags:
//                  [0] carry  [1] underflow  [2] zero
//                  [3] equal  [4] greater    [5] smaller
// ---------------------------------------------------------------------------
module alu_j #(
  parameter int DataWidth     = 8,
  parameter int NumOpCodeBits = 5,
  parameter int ParamBits     = 8,
  parameter int NumStatusBits = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NumOpCodeBits-1:0] opcode,
  input  logic [DataWidth-1:0]     operand1,
  input  logic [DataWidth-1:0]     operand2,
  input  logic [ParamBits-1:0]     param,
  output logic [DataWidth-1:0]     result,
  output logic [NumStatusBits-1:0] status
);

  localparam logic [NumOpCodeBits-1:0] OpAdd = NumOpCodeBits'(1);
  localparam logic [NumOpCodeBits-1:0] OpSub = NumOpCodeBits'(2);
  localparam logic [NumOpCodeBits-1:0] OpAnd = NumOpCodeBits'(3);
  localparam logic [NumOpCodeBits-1:0] OpOr  = NumOpCodeBits'(4);
  localparam logic [NumOpCodeBits-1:0] OpNot = NumOpCodeBits'(5);
  localparam logic [NumOpCodeBits-1:0] OpXor = NumOpCodeBits'(6);
  localparam logic [NumOpCodeBits-1:0] OpShl = NumOpCodeBits'(7);
  localparam logic [NumOpCodeBits-1:0] OpShr = NumOpCodeBits'(8);
  localparam logic [NumOpCodeBits-1:0] OpVal = NumOpCodeBits'(9);
  localparam logic [NumOpCodeBits-1:0] OpCmp = NumOpCodeBits'(10);

  localparam int StCarry   = 0;
  localparam int StUnder   = 1;
  localparam int StZero    = 2;
  localparam int StEqual   = 3;
  localparam int StGreater = 4;
  localparam int StSmaller = 5;

  logic [DataWidth-1:0]     result_q, result_d;
  logic [NumStatusBits-1:0] status_q, status_d;

  logic [DataWidth:0]   sum;
  logic [DataWidth-1:0] diff;
  logic                 op_eq, op_gt, op_lt;

  logic carry, underflow, zero, cmp_en;

  assign sum   = {1'b0, operand1} + {1'b0, operand2};
  assign diff  = operand1 - operand2;
  assign op_eq = (operand1 == operand2);
  assign op_gt = (operand1 >  operand2);
  assign op_lt = (operand1 <  operand2);

  always_comb begin
    result_d  = '0;
    carry     = 1'b0;
    underflow = 1'b0;
    zero      = 1'b0;
    cmp_en    = 1'b0;

    unique case (opcode)
      OpAdd: begin
        result_d = sum[DataWidth-1:0];
        carry    = sum[DataWidth];
        // zero looks at the full sum, so an overflow to 0 is not "zero"
        zero     = (sum == '0);
        cmp_en   = 1'b1;
      end
      OpSub: begin
        result_d  = diff;
        underflow = op_lt;
        zero      = op_eq;
        cmp_en    = 1'b1;
      end
      OpAnd: begin
        result_d = operand1 & operand2;
        zero     = (result_d == '0);
        cmp_en   = 1'b1;
      end
      OpOr: begin
        result_d = operand1 | operand2;
        zero     = (result_d == '0);
        cmp_en   = 1'b1;
      end
      OpXor: begin
        result_d = operand1 ^ operand2;
        zero     = (result_d == '0);
        cmp_en   = 1'b1;
      end
      OpNot: begin
        result_d = ~operand2;
        zero     = (result_d == '0);
      end
      OpShl: begin
        // logical shift by the full param value; amounts >= DataWidth give 0
        result_d = operand1 << param;
        zero     = (result_d == '0);
      end
      OpShr: begin
        result_d = operand1 >> param;
        zero     = (result_d == '0);
      end
      OpVal: begin
        result_d = DataWidth'(param);
        zero     = (param == '0);
      end
      OpCmp: begin
        cmp_en = 1'b1;
      end
      default: begin
        // NOP and every unassigned opcode: all outputs stay cleared
      end
    endcase
  end

  always_comb begin
    status_d             = '0;
    status_d[StCarry]    = carry;
    status_d[StUnder]    = underflow;
    status_d[StZero]     = zero;
    status_d[StEqual]    = cmp_en & op_eq;
    status_d[StGreater]  = cmp_en & op_gt;
    status_d[StSmaller]  = cmp_en & op_lt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q <= '0;
      status_q <= '0;
    end else begin
      result_q <= result_d;
      status_q <= status_d;
    end
  end

  assign result = result_q;
  assign status = status_q;

endmodule

// File: tb/tb_alu_j.sv
// ---------------------------------------------------------------------------
// tb_alu_j : self-checking bench for alu_j (default parameters)
// Directed vector table, hand-written reset sequences, then randomized
// operations compared against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_alu_j;

  logic       clk;
  logic       rst_n;
  logic [4:0] opcode;
  logic [7:0] operand1;
  logic [7:0] operand2;
  logic [7:0] param;
  logic [7:0] result;
  logic [5:0] status;

  int checks   = 0;
  int failures = 0;

  alu_j dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .opcode   (opcode),
    .operand1 (operand1),
    .operand2 (operand2),
    .param    (param),
    .result   (result),
    .status   (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] p;
    logic [7:0] exp_r;
    logic [5:0] exp_s;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(string n, logic [4:0] op, logic [7:0] a, logic [7:0] b,
                                  logic [7:0] p, logic [7:0] er, logic [5:0] es);
    vec_t v;
    v.name = n; v.op = op; v.a = a; v.b = b; v.p = p; v.exp_r = er; v.exp_s = es;
    vecs.push_back(v);
  endfunction

  // Reference model: operates on plain integers straight from the op rules.
  function automatic void ref_model(input int op, input int a, input int b, input int p,
                                    output int r, output int s);
    int  c, u, z;
    bit  cmp;
    r = 0; c = 0; u = 0; z = 0; cmp = 0;
    case (op)
      1:  begin r = (a + b) % 256; c = (a + b > 255); z = (a + b == 0); cmp = 1; end
      2:  begin r = (a - b + 256) % 256; u = (a < b); z = (a == b); cmp = 1; end
      3:  begin r = a & b; z = (r == 0); cmp = 1; end
      4:  begin r = a | b; z = (r == 0); cmp = 1; end
      5:  begin r = 255 - b; z = (r == 0); end
      6:  begin r = a ^ b; z = (r == 0); cmp = 1; end
      7:  begin r = (p >= 8) ? 0 : (a * (1 << p)) % 256; z = (r == 0); end
      8:  begin r = (p >= 8) ? 0 : a / (1 << p); z = (r == 0); end
      9:  begin r = p; z = (p == 0); end
      10: cmp = 1;
      default: ;
    endcase
    s = c + 2 * u + 4 * z;
    if (cmp) begin
      if (a == b)     s += 8;
      else if (a > b) s += 16;
      else            s += 32;
    end
  endfunction

  task automatic check(string n, logic [7:0] er, logic [5:0] es);
    checks++;
    if (result !== er || status !== es) begin
      failures++;
      $display("FAIL %s: got result=%h status=%b, want result=%h status=%b",
               n, result, status, er, es);
    end
  endtask

  // Drive inputs on the falling edge, let the rising edge capture, sample 1ns later.
  task automatic apply(logic rn, logic [4:0] op, logic [7:0] a, logic [7:0] b, logic [7:0] p);
    @(negedge clk);
    rst_n = rn; opcode = op; operand1 = a; operand2 = b; param = p;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int r, s;
    rst_n = 1'b0; opcode = 5'd1; operand1 = 8'hFF; operand2 = 8'h01; param = 8'h00;

    add_vec("add_255_1",   5'd1,  8'hFF, 8'h01, 8'h00, 8'h00, 6'b010001);
    add_vec("add_0_0",     5'd1,  8'h00, 8'h00, 8'h00, 8'h00, 6'b001100);
    add_vec("add_200_100", 5'd1,  8'hC8, 8'h64, 8'h00, 8'h2C, 6'b010001);
    add_vec("sub_0e_0f",   5'd2,  8'h0E, 8'h0F, 8'h00, 8'hFF, 6'b100010);
    add_vec("sub_7e_7e",   5'd2,  8'h7E, 8'h7E, 8'h00, 8'h00, 6'b001100);
    add_vec("and_zero",    5'd3,  8'hF0, 8'h0F, 8'h00, 8'h00, 6'b010100);
    add_vec("or_ff",       5'd4,  8'hF0, 8'h0F, 8'h00, 8'hFF, 6'b010000);
    add_vec("xor_same",    5'd6,  8'h55, 8'h55, 8'h00, 8'h00, 6'b001100);
    add_vec("not_ff",      5'd5,  8'h0F, 8'hFF, 8'h00, 8'h00, 6'b000100);
    add_vec("not_ac",      5'd5,  8'h12, 8'hAC, 8'h00, 8'h53, 6'b000000);
    add_vec("shl_06_3",    5'd7,  8'h06, 8'h00, 8'h03, 8'h30, 6'b000000);
    add_vec("shr_66_4",    5'd8,  8'h66, 8'h00, 8'h04, 8'h06, 6'b000000);
    add_vec("shl_f6_33",   5'd7,  8'hF6, 8'h00, 8'h33, 8'h00, 6'b000100);
    add_vec("shr_f6_33",   5'd8,  8'hF6, 8'h00, 8'h33, 8'h00, 6'b000100);
    add_vec("shl_01_7",    5'd7,  8'h01, 8'h00, 8'h07, 8'h80, 6'b000000);
    add_vec("shl_01_8",    5'd7,  8'h01, 8'h00, 8'h08, 8'h00, 6'b000100);
    add_vec("shr_80_7",    5'd8,  8'h80, 8'h00, 8'h07, 8'h01, 6'b000000);
    add_vec("cmp_gt",      5'd10, 8'hF6, 8'h00, 8'h00, 8'h00, 6'b010000);
    add_vec("cmp_eq",      5'd10, 8'hF6, 8'hF6, 8'h00, 8'h00, 6'b001000);
    add_vec("cmp_lt",      5'd10, 8'h76, 8'hF6, 8'h00, 8'h00, 6'b100000);
    add_vec("val_0",       5'd9,  8'h33, 8'h44, 8'h00, 8'h00, 6'b000100);
    add_vec("val_a5",      5'd9,  8'h33, 8'h44, 8'hA5, 8'hA5, 6'b000000);
    add_vec("nop_0",       5'd0,  8'hFF, 8'h01, 8'h05, 8'h00, 6'b000000);
    add_vec("nop_11",      5'd11, 8'hFF, 8'h01, 8'h05, 8'h00, 6'b000000);
    add_vec("nop_1f",      5'd31, 8'h00, 8'h00, 8'h00, 8'h00, 6'b000000);

    // Reset with live non-zero inputs must clear outputs.
    apply(1'b0, 5'd1, 8'hFF, 8'h01, 8'h00);
    check("reset_state", 8'h00, 6'b000000);

    foreach (vecs[i]) begin
      apply(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].p);
      check(vecs[i].name, vecs[i].exp_r, vecs[i].exp_s);
    end

    // In-flight op discarded by reset, then first released edge computes.
    apply(1'b1, 5'd1, 8'h01, 8'h03, 8'h00);
    check("add_1_3_pre", 8'h04, 6'b100000);
    apply(1'b1, 5'd9, 8'h00, 8'h00, 8'h7E);
    check("val_7e", 8'h7E, 6'b000000);
    apply(1'b0, 5'd1, 8'h01, 8'h03, 8'h00);
    check("reset_mid", 8'h00, 6'b000000);
    apply(1'b1, 5'd1, 8'h01, 8'h03, 8'h00);
    check("release_add", 8'h04, 6'b100000);
    apply(1'b1, 5'd31, 8'h01, 8'h03, 8'h00);
    check("op_1f", 8'h00, 6'b000000);

    // Reset must not act between edges.
    apply(1'b1, 5'd4, 8'hA0, 8'h05, 8'h00);
    check("or_a5", 8'hA5, 6'b010000);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    check("no_async_reset", 8'hA5, 6'b010000);
    @(posedge clk);
    #1;
    check("sync_reset_edge", 8'h00, 6'b000000);

    // Randomized back-to-back operations against the reference model.
    for (int i = 0; i < 400; i++) begin
      logic [4:0] op;
      logic [7:0] a, b, p;
      op = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 10));
      a  = 8'($urandom);
      b  = ($urandom_range(0, 7) == 0) ? a : 8'($urandom);
      p  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 9)) : 8'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        a = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
        b = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'h01;
      end
      ref_model(int'(op), int'(a), int'(b), int'(p), r, s);
      apply(1'b1, op, a, b, p);
      check($sformatf("rand%0d_op%0d", i, op), 8'(r), 6'(s));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_j.md
ALU_J -- requirements
Module: alu_j

Interface
REQ-001 Parameter DataWidth, default 8, SHALL set operand and result width.
REQ-002 Parameter NumOpCodeBits, default 5, SHALL set opcode width.
REQ-003 Parameter ParamBits, default 8, SHALL set param width.
REQ-004 Parameter NumStatusBits, default 6, SHALL set status width.
REQ-005 The block SHALL use one clock; reset is synchronous and active-low.
REQ-006 Port clk, input, 1: rising-edge clock.
REQ-007 Port rst_n, input, 1: synchronous active-low reset.
REQ-008 Port opcode, input, NumOpCodeBits: operation select.
REQ-009 Port operand1, input, DataWidth: first operand.
REQ-010 Port operand2, input, DataWidth: second operand.
REQ-011 Port param, input, ParamBits: shift amount or immediate value.
REQ-012 Port result, output, DataWidth: registered result.
REQ-013 Port status, output, NumStatusBits: registered flags; bit0 carry, bit1 underflow, bit2 zero, bit3 equal, bit4 greater, bit5 smaller.

Function
REQ-014 Inputs SHALL be sampled on each rising clk edge with rst_n high; result and status SHALL update on that same edge (1-cycle latency, no handshake, new operation every cycle).
REQ-015 Opcode map: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 NOT, 6 XOR, 7 SHL, 8 SHR, 9 VAL, 10 CMP; codes 11-31 SHALL behave as NOP.
REQ-016 Unless a REQ sets a flag, it SHALL be 0.
REQ-017 ADD: result = (operand1+operand2) mod 256; carry = bit 8 of the 9-bit sum; zero = 1 only when the full 9-bit sum is 0 (255+1 gives carry=1, zero=0).
REQ-018 SUB: result = (operand1-operand2) mod 256; underflow = operand1<operand2; zero = 1 only when operand1==operand2.
REQ-019 AND/OR/XOR: bitwise on operand1, operand2; zero = (result==0).
REQ-020 For ADD, SUB, AND, OR, XOR: equal = (operand1==operand2), greater = (operand1>operand2), smaller = (operand1<operand2), unsigned.
REQ-021 NOT: result = ~operand2; zero = (result==0); operand1 ignored; no compare flags.
REQ-022 SHL/SHR: result = operand1 shifted logically by the full unsigned param value, zero-fill; param >= 8 gives result 0; zero = (result==0); no carry, no compare flags.
REQ-023 VAL: result = param; zero = (param==0).
REQ-024 CMP: result = 0; equal/greater/smaller per REQ-020; zero SHALL be 0.
REQ-025 NOP: result = 0, status = 0.
REQ-026 Exactly one of equal/greater/smaller SHALL be set for ops in REQ-020 and CMP; none for others.

Reset
REQ-027 With rst_n low at a rising clk edge, result and status SHALL become 0 regardless of other inputs; the reset SHALL have no asynchronous effect.
REQ-028 The first edge with rst_n high SHALL produce the result of the inputs present at that edge; reset asserted mid-stream SHALL discard the in-flight operation.

Verification
REQ-029 ADD 255+1 -> next edge result 0x00, status 0b010001 (carry, greater); ADD 0+0 -> result 0, status 0b001100 (zero, equal).
REQ-030 SUB 0x0E-0x0F -> result 0xFF, status 0b100010 (underflow, smaller); SUB 0x7E-0x7E -> result 0, status 0b001100.
REQ-031 NOT operand1=0x0F, operand2=0xFF -> result 0, status 0b000100; NOT operand2=0xAC -> result 0x53, status 0.
REQ-032 SHL 0x06 by 3 -> result 0x30, status 0; SHR 0x66 by 4 -> 0x06, status 0; SHL/SHR 0xF6 by 0x33 -> result 0, status 0b000100.
REQ-033 CMP 0xF6 vs 0x00 -> result 0, status 0b010000; 0xF6 vs 0xF6 -> 0b001000; 0x76 vs 0xF6 -> 0b100000.
REQ-034 Drive ADD 1+3, assert rst_n low for one edge -> outputs 0; release -> next edge result 4, status 0b100000; opcode 0x1F -> result 0, status 0.
